// File: rtl/bf_step_sequencer.sv
// Single-clock phase sequencer for the Brainfuck core: issues one-cycle enables
// to the data RAM, core and SFR, owns the data pointer and services debug reads.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | between instructions; arbitrates finish, debug, go
// S_READ     | RAM read of the cell at the data pointer
// S_DECODE   | RAM data valid; core_en strobe, core registers its results
// S_WRITE    | write slot; if dout & sfr_busy it is spent waiting instead
// S_SFR_WAIT | holding the write until the SFR can accept it
// S_DBG_READ | RAM read at dbg_addr
// S_DBG_DATA | capture debug data; ack follows next cycle with the data
// S_HALT     | ROM overrun; only debug reads until reset
module bf_step_sequencer #(
  parameter int PRESCALE = 100,
  parameter int AW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_step,
  input  logic          i_finish,
  input  logic          i_dout,
  input  logic [AW-1:0] i_core_next_addr,
  input  logic          i_sfr_busy,
  input  logic [7:0]    i_ram_val,
  input  logic          i_dbg_req,
  input  logic [AW-1:0] i_dbg_addr,
  output logic          o_ram_ce,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_ad,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_core_en,
  output logic          o_sfr_we,
  output logic          o_dbg_ack,
  output logic [7:0]    o_dbg_data,
  output logic          o_halted,
  output logic [15:0]   o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DECODE, S_SFR_WAIT, S_WRITE, S_DBG_READ, S_DBG_DATA, S_HALT
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre_cnt;
  logic          r_tick_pend;
  logic          r_step_pend;
  logic [AW-1:0] r_ram_addr;
  logic [15:0]   r_instr_count;
  logic [7:0]    r_dbg_data;
  logic          r_dbg_ack;
  logic          r_halted;

  logic          w_wrap;
  logic          w_go;
  logic          w_dbg_go;
  logic          w_write_ok;
  logic          w_start;
  logic          w_do_write;
  logic          w_dbg_done;
  logic          w_ram_ce;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_ad;
  logic          w_core_en;
  logic          w_sfr_we;

  assign w_wrap     = (r_pre_cnt == PW'(PRESCALE - 1));
  assign w_go       = (i_run & r_tick_pend) | (~i_run & r_step_pend);
  // The ack cycle still sees dbg_req held high; it must not start a second read.
  assign w_dbg_go   = i_dbg_req & ~r_dbg_ack;
  assign w_write_ok = ~(i_dout & i_sfr_busy);

  always_comb begin
    w_state_nxt = r_state;
    w_ram_ce    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_ad    = r_ram_addr;
    w_core_en   = 1'b0;
    w_sfr_we    = 1'b0;
    w_start     = 1'b0;
    w_do_write  = 1'b0;
    w_dbg_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_finish) begin
          w_state_nxt = S_HALT;
        end else if (w_dbg_go) begin
          w_state_nxt = S_DBG_READ;
        end else if (w_go) begin
          w_state_nxt = S_READ;
          w_start     = 1'b1;
        end
      end
      S_READ: begin
        w_ram_ce    = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_core_en   = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE, S_SFR_WAIT: begin
        if (w_write_ok) begin
          w_ram_ce    = 1'b1;
          w_ram_we    = 1'b1;
          w_sfr_we    = i_dout;
          w_do_write  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SFR_WAIT;
        end
      end
      S_DBG_READ: begin
        w_ram_ce    = 1'b1;
        w_ram_ad    = i_dbg_addr;
        w_state_nxt = S_DBG_DATA;
      end
      S_DBG_DATA: begin
        w_dbg_done  = 1'b1;
        w_state_nxt = r_halted ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        if (w_dbg_go) w_state_nxt = S_DBG_READ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pre_cnt     <= '0;
      r_tick_pend   <= 1'b0;
      r_step_pend   <= 1'b0;
      r_ram_addr    <= '0;
      r_instr_count <= '0;
      r_dbg_data    <= '0;
      r_dbg_ack     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre_cnt   <= w_wrap ? '0 : r_pre_cnt + PW'(1);
      // A new tick or step in the consuming cycle survives the clear.
      r_tick_pend <= (r_tick_pend & ~w_start) | w_wrap;
      r_step_pend <= r_halted ? 1'b0 : ((r_step_pend & ~w_start) | i_step);
      r_dbg_ack   <= w_dbg_done;
      if (w_dbg_done) r_dbg_data <= i_ram_val;
      if (w_do_write) begin
        r_ram_addr    <= i_core_next_addr;
        r_instr_count <= r_instr_count + 16'd1;
      end
      if (w_state_nxt == S_HALT) r_halted <= 1'b1;
    end
  end

  // Strobes are masked during reset so an aborted instruction never writes.
  assign o_ram_ce      = w_ram_ce  & ~i_rst;
  assign o_ram_we      = w_ram_we  & ~i_rst;
  assign o_core_en     = w_core_en & ~i_rst;
  assign o_sfr_we      = w_sfr_we  & ~i_rst;
  assign o_ram_ad      = w_ram_ad;
  assign o_ram_addr    = r_ram_addr;
  assign o_instr_count = r_instr_count;
  assign o_dbg_data    = r_dbg_data;
  assign o_dbg_ack     = r_dbg_ack;
  assign o_halted      = r_halted;

endmodule

// File: doc/bf_step_sequencer.md
# bf_step_sequencer

Single-clock phase sequencer for the Brainfuck core datapath. Replaces the divided, clock-gated read/decode/write phase clocks with a state machine that issues one-cycle clock enables to the single-port data RAM, the core and the SFR block. Also owns the data-pointer register, stalls SFR writes while the SFR is busy, halts on ROM overrun, and lets a debug port read RAM between instructions.

## Interface
- PRESCALE, 100: clk cycles per execution tick in run mode (≥2)
- AW, 8: RAM address / data-pointer width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; free-run one instruction per tick
- step  in  1  one-cycle pulse; execute exactly one instruction when run=0
- finish  in  1  ROM overrun flag from program ROM
- dout  in  1  core: current instruction writes the SFR
- core_next_addr  in  AW  core's next data-pointer value
- sfr_busy  in  1  SFR cannot accept a write this cycle
- ram_val  in  8  RAM read data, valid the cycle after a ce
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  AW  debug read address, stable while dbg_req=1
- ram_ce  out  1  RAM access enable
- ram_we  out  1  RAM write enable (only with ram_ce)
- ram_ad  out  AW  RAM address
- ram_addr  out  AW  data-pointer register
- core_en  out  1  core decode/PC-advance strobe
- sfr_we  out  1  SFR write strobe
- dbg_ack  out  1  one-cycle debug read completion
- dbg_data  out  8  debug read data, held until next dbg read
- halted  out  1  sequencer in HALT
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE, READ, DECODE, SFR_WAIT, WRITE, DBG_READ, DBG_DATA, HALT.
- Prescaler: counter 0..PRESCALE-1, free-running; wrap sets tick_pend. step pulse sets step_pend. go = (run & tick_pend) | (~run & step_pend).
- IDLE priority: finish=1 → HALT; else dbg_req → DBG_READ; else go → READ, clearing both tick_pend and step_pend.
- READ: ram_ce=1, ram_ad=ram_addr → DECODE.
- DECODE: ram_val valid; core_en=1 for one cycle. Core registers next_addr/next_val/dout/din on this edge. Next: SFR_WAIT if dout&sfr_busy, else WRITE (dout, sfr_busy sampled the cycle after DECODE, i.e. in the next-state decision made from registered core outputs).
- SFR_WAIT: no strobes; leaves to WRITE in the cycle after sfr_busy=0.
- WRITE: ram_ce=1, ram_we=1, ram_ad=ram_addr, sfr_we=dout; ram_addr ← core_next_addr; instr_count+1 (wraps at 16 bits) → IDLE.
- DBG_READ: ram_ce=1, ram_ad=dbg_addr → DBG_DATA. DBG_DATA: dbg_data ← ram_val, dbg_ack=1 → IDLE, or HALT if entered from HALT.
- HALT: halted=1; only debug reads serviced; exit only via rst. run/step ignored; step_pend cleared.
- At most one of ram_ce (per address source), core_en, sfr_we active per cycle except WRITE (ram_ce, ram_we, sfr_we together).

## Timing
- Reset: state IDLE, ram_addr=0, instr_count=0, dbg_data=0, prescale counter=0, pends=0; all strobes, dbg_ack, halted =0. rst mid-instruction aborts with no write issued.
- Instruction latency without stall: 4 cycles IDLE→READ→DECODE→WRITE→IDLE; each SFR_WAIT cycle adds 1.
- Debug read: dbg_req seen in IDLE → dbg_ack 3 cycles later; dbg_req arriving mid-instruction waits until IDLE.
- Ticks during an instruction are held in tick_pend (at most one pending; extra ticks merge).
- step while run=1 is latched but ignored until run=0 (then executes once). step while instruction busy: latched, executes after.
- finish rising mid-instruction: current instruction completes, HALT on return to IDLE.
- dbg_req and go simultaneous in IDLE: debug wins; instruction starts the following IDLE.

## Test plan
- Reset, run=1, PRESCALE=4, sfr_busy=0, core_next_addr=ram_addr+1: core_en every 4 cycles, ram_addr 0→1→2, instr_count increments per WRITE.
- run=0, step pulse ×2 spaced 10 cycles: exactly two READ/DECODE/WRITE sequences, instr_count=2, no activity otherwise.
- dout=1, sfr_busy high 5 cycles after DECODE: 5 SFR_WAIT cycles, single sfr_we with ram_we in WRITE, ram_addr updated once.
- dbg_req with dbg_addr=0x2A in IDLE, RAM holds 0x5C there: ram_ad=0x2A with ce, dbg_ack 3 cycles later, dbg_data=0x5C.
- finish=1 during DECODE: WRITE completes, halted=1, further ticks/steps ignored, debug read still acknowledged; rst returns IDLE with ram_addr=0.
- rst asserted in DECODE: no ram_we or sfr_we issued, all outputs at reset values next cycle.
